spi_slave_cfg: RTL and testbench

//  Parametrised SPI slave: any CPOL/CPHA mode, configurable word width and bit order, multi-word frames per SS assertion.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_pin_sync.sv | 42 ++++
 rtl/spi_slave_cfg.sv | 203 ++++++++++++++++++++
 tb/tb_spi_slave_cfg.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI slave: mode encodings, synchroniser depth
// and the frame state type.
package spi_pkg;

    localparam int SPI_SYNC = 3;

    // Modes are encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } frame_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and decodes SCK and SS edges.
module spi_pin_sync
    import spi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);

    logic [SPI_SYNC-1:0] sck_q;
    logic [SPI_SYNC-1:0] ss_q;
    logic [SPI_SYNC-1:0] mosi_q;

    // Bit SPI_SYNC-1 is the first stage; bit 0 is the oldest value in each chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q  <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck,  sck_q[SPI_SYNC-1:1]};
            ss_q   <= {ss,   ss_q[SPI_SYNC-1:1]};
            mosi_q <= {mosi, mosi_q[SPI_SYNC-1:1]};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[0];
    assign sck_fall = ~sck_q[1] & sck_q[0];
    assign ss_fall  = ~ss_q[1] & ss_q[0];
    assign ss_rise  = ss_q[1] & ~ss_q[0];

    // Data is taken from the same depth as the old SCK level, i.e. just before the edge
    assign mosi_s = mosi_q[0];

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI slave for any CPOL/CPHA mode with configurable word width and bit order, a valid/ready
// TX holding register with idle fill, and frame/word strobes in the clk domain.
module spi_slave_cfg
    import spi_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter bit               CPOL      = 1'b0,
    parameter bit               CPHA      = 1'b1,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] TX_IDLE   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_first,
    output logic             frame_start,
    output logic             frame_end
);

    localparam logic [1:0] MODE           = {CPOL, CPHA};
    localparam bit         SAMPLE_ON_LEAD = (MODE == MODE0) || (MODE == MODE2);
    localparam bit         IDLE_HIGH      = (MODE == MODE2) || (MODE == MODE3);
    localparam int         CW             = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);

    logic sck_rise;
    logic sck_fall;
    logic ss_fall;
    logic ss_rise;
    logic mosi_s;

    frame_state_t state;
    frame_state_t state_next;

    logic frame_begin;
    logic frame_stop;
    logic in_word;

    logic             lead;
    logic             trail;
    logic             sample_edge;
    logic             do_sample;
    logic             word_done;
    logic             load;
    logic             shift;
    logic             load_pending;
    logic             first;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] rx_shreg;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_shreg;
    logic [WIDTH-1:0] tx_shifted;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             ready_en;
    logic             accept;

    spi_pin_sync u_pin_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .ss       (ss),
        .mosi     (mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .mosi_s   (mosi_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (ss_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: if (ss_rise) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // SCK activity is only acted on inside a frame and not in the cycle SS deasserts
    always_comb begin
        frame_begin = 1'b0;
        frame_stop  = 1'b0;
        in_word     = 1'b0;
        case (state)
            ST_IDLE: begin
                frame_begin = ss_fall;
            end
            ST_ACTIVE: begin
                frame_stop = ss_rise;
                in_word    = ~ss_rise;
            end
            default: begin
                frame_begin = 1'b0;
            end
        endcase
    end

    assign lead        = IDLE_HIGH ? sck_fall : sck_rise;
    assign trail       = IDLE_HIGH ? sck_rise : sck_fall;
    assign sample_edge = SAMPLE_ON_LEAD ? lead : trail;
    assign do_sample   = in_word & sample_edge;
    assign word_done   = do_sample & (bitcnt == LAST_BIT);

    // With CPHA=0 the trailing edge after the last sample must not disturb the freshly loaded word
    assign load  = SAMPLE_ON_LEAD ? (frame_begin | (in_word & load_pending))
                                  : (in_word & lead & (bitcnt == '0));
    assign shift = SAMPLE_ON_LEAD ? (in_word & trail & (bitcnt != '0))
                                  : (in_word & lead & (bitcnt != '0));

    assign rx_next    = MSB_FIRST ? {rx_shreg[WIDTH-2:0], mosi_s} : {mosi_s, rx_shreg[WIDTH-1:1]};
    assign tx_shifted = MSB_FIRST ? {tx_shreg[WIDTH-2:0], 1'b0} : {1'b0, tx_shreg[WIDTH-1:1]};

    assign tx_ready = ready_en & ~hold_full;
    assign accept   = tx_valid & tx_ready;

    assign miso_oe = (state == ST_ACTIVE);
    assign miso    = miso_oe & (MSB_FIRST ? tx_shreg[WIDTH-1] : tx_shreg[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt       <= '0;
            first        <= 1'b0;
            load_pending <= 1'b0;
            rx_shreg     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_first     <= 1'b0;
            tx_shreg     <= '0;
            tx_underrun  <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
        end else begin
            frame_start  <= frame_begin;
            frame_end    <= frame_stop;
            rx_valid     <= word_done;
            load_pending <= word_done & SAMPLE_ON_LEAD;
            tx_underrun  <= load & ~hold_full;

            if (frame_begin) begin
                first <= 1'b1;
            end

            if (frame_begin || frame_stop) begin
                bitcnt <= '0;
            end else if (do_sample) begin
                rx_shreg <= rx_next;
                if (word_done) begin
                    rx_data  <= rx_next;
                    rx_first <= first;
                    first    <= 1'b0;
                    bitcnt   <= '0;
                end else begin
                    bitcnt <= bitcnt + CW'(1);
                end
            end

            if (load) begin
                tx_shreg <= hold_full ? hold_data : TX_IDLE;
            end else if (shift) begin
                tx_shreg <= tx_shifted;
            end
        end
    end

    // A write can only land while the register is empty, so it never collides with a load's read
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end
            if (accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Scoreboard bench: four WIDTH=8 slaves (modes 0..3) share one SPI bus; a WIDTH=16 LSB-first
// mode-1 slave sits on a second select line.
module tb_spi_slave_cfg;

    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sck_base;
    logic        ss_a;
    logic        ss_b;
    logic        mosi;
    logic [7:0]  tx_data8;
    logic        tx_valid8;
    logic [15:0] tx_data16;
    logic        tx_valid16;

    logic        miso_all        [5];
    logic        miso_oe_all     [5];
    logic        tx_ready_all    [5];
    logic        tx_underrun_all [5];
    logic        rx_valid_all    [5];
    logic        rx_first_all    [5];
    logic        frame_start_all [5];
    logic        frame_end_all   [5];
    logic [7:0]  rx_data8        [4];
    logic [15:0] rx_data16;

    int tests_run    = 0;
    int tests_failed = 0;

    int fs_cnt [5];
    int fe_cnt [5];
    int ur_cnt [5];
    int fs_ref [5];
    int fe_ref [5];
    int ur_ref [5];

    logic [16:0] exp_rx   [5][$];
    logic [15:0] exp_miso [5][$];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        logic sck_m;
        assign sck_m = (m >= 2) ? ~sck_base : sck_base;
        spi_slave_cfg #(
            .WIDTH     (8),
            .CPOL      (1'(m / 2)),
            .CPHA      (1'(m % 2)),
            .MSB_FIRST (1'b1),
            .TX_IDLE   (8'h00)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .sck         (sck_m),
            .ss          (ss_a),
            .mosi        (mosi),
            .miso        (miso_all[m]),
            .miso_oe     (miso_oe_all[m]),
            .tx_data     (tx_data8),
            .tx_valid    (tx_valid8),
            .tx_ready    (tx_ready_all[m]),
            .tx_underrun (tx_underrun_all[m]),
            .rx_data     (rx_data8[m]),
            .rx_valid    (rx_valid_all[m]),
            .rx_first    (rx_first_all[m]),
            .frame_start (frame_start_all[m]),
            .frame_end   (frame_end_all[m])
        );
    end

    spi_slave_cfg #(
        .WIDTH     (16),
        .CPOL      (1'b0),
        .CPHA      (1'b1),
        .MSB_FIRST (1'b0),
        .TX_IDLE   (16'h0000)
    ) u_dut16 (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck_base),
        .ss          (ss_b),
        .mosi        (mosi),
        .miso        (miso_all[4]),
        .miso_oe     (miso_oe_all[4]),
        .tx_data     (tx_data16),
        .tx_valid    (tx_valid16),
        .tx_ready    (tx_ready_all[4]),
        .tx_underrun (tx_underrun_all[4]),
        .rx_data     (rx_data16),
        .rx_valid    (rx_valid_all[4]),
        .rx_first    (rx_first_all[4]),
        .frame_start (frame_start_all[4]),
        .frame_end   (frame_end_all[4])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] rxWord(input int m);
        return (m == 4) ? rx_data16 : {8'h00, rx_data8[m]};
    endfunction

    // Pulse counters and the receive scoreboard, sampled away from the active edge
    always @(negedge clk) begin
        logic [16:0] e;
        for (int m = 0; m < 5; m++) begin
            if (frame_start_all[m]) fs_cnt[m]++;
            if (frame_end_all[m])   fe_cnt[m]++;
            if (tx_underrun_all[m]) ur_cnt[m]++;
            if (rx_valid_all[m]) begin
                if (exp_rx[m].size() == 0) begin
                    checkOutput($sformatf("rx_unexpected_d%0d", m), exp_rx[m].size(), 1);
                end else begin
                    e = exp_rx[m].pop_front();
                    checkOutput($sformatf("rx_d%0d", m), {rx_first_all[m], rxWord(m)}, e);
                end
            end
        end
    end

    task automatic snapCounts();
        for (int m = 0; m < 5; m++) begin
            fs_ref[m] = fs_cnt[m];
            fe_ref[m] = fe_cnt[m];
            ur_ref[m] = ur_cnt[m];
        end
    endtask

    task automatic writeHold(input bit sel16, input logic [15:0] d);
        int   t;
        logic rdy;
        t = 0;
        @(negedge clk);
        rdy = sel16 ? tx_ready_all[4]
                    : (tx_ready_all[0] & tx_ready_all[1] & tx_ready_all[2] & tx_ready_all[3]);
        while (!rdy && t < 100) begin
            @(negedge clk);
            t++;
            rdy = sel16 ? tx_ready_all[4]
                        : (tx_ready_all[0] & tx_ready_all[1] & tx_ready_all[2] & tx_ready_all[3]);
        end
        checkOutput("tx_ready_wait", rdy, 1);
        if (sel16) begin
            tx_data16  = d;
            tx_valid16 = 1'b1;
        end else begin
            tx_data8  = d[7:0];
            tx_valid8 = 1'b1;
        end
        @(negedge clk);
        tx_valid8  = 1'b0;
        tx_valid16 = 1'b0;
        if (sel16) begin
            checkOutput("tx_ready_full_d4", tx_ready_all[4], 0);
        end else begin
            checkOutput("tx_ready_full_d1", tx_ready_all[1], 0);
        end
    endtask

    // SPI master: each mosi bit is stable from half a half-period before the leading edge
    // to half a half-period after the trailing edge, so CPHA=0 and CPHA=1 slaves both see it
    task automatic applyStimulus(input bit sel16, input int nbits, input logic [47:0] words,
                                 input bit leave_low);
        int          width;
        int          w;
        int          b;
        logic [15:0] cap [5];
        logic [15:0] e;
        width = sel16 ? 16 : 8;
        for (int m = 0; m < 5; m++) cap[m] = '0;
        @(negedge clk);
        if (sel16) ss_b = 1'b0; else ss_a = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            w = k / width;
            b = k % width;
            mosi = sel16 ? words[w*16 + b] : words[w*8 + 7 - b];
            repeat (HALF/2) @(negedge clk);
            if (!sel16) begin
                cap[0][7-b] = miso_all[0];
                cap[2][7-b] = miso_all[2];
            end
            sck_base = 1'b1;
            repeat (HALF) @(negedge clk);
            if (sel16) begin
                cap[4][b] = miso_all[4];
            end else begin
                cap[1][7-b] = miso_all[1];
                cap[3][7-b] = miso_all[3];
            end
            if (k == 0) begin
                checkOutput("miso_oe_active", sel16 ? miso_oe_all[4] : miso_oe_all[1], 1);
            end
            sck_base = 1'b0;
            repeat (HALF/2) @(negedge clk);
            if (b == width - 1) begin
                for (int m = 0; m < 5; m++) begin
                    if ((m == 4) == sel16) begin
                        if (exp_miso[m].size() == 0) begin
                            checkOutput($sformatf("miso_unexpected_d%0d", m), exp_miso[m].size(), 1);
                        end else begin
                            e = exp_miso[m].pop_front();
                            checkOutput($sformatf("miso_d%0d", m), cap[m], e);
                        end
                    end
                end
            end
        end
        if (!leave_low) begin
            ss_a = 1'b1;
            ss_b = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic pushModes(input logic [7:0] miso_word, input logic first, input logic [7:0] rx_word);
        for (int m = 0; m < 4; m++) begin
            exp_miso[m].push_back({8'h00, miso_word});
            exp_rx[m].push_back({first, 8'h00, rx_word});
        end
    endtask

    task automatic checkDeltas(input string tag, input int fs, input int fe, input int ur_cpha0,
                               input int ur_cpha1);
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("%s_fs_d%0d", tag, m), fs_cnt[m] - fs_ref[m], fs);
            checkOutput($sformatf("%s_fe_d%0d", tag, m), fe_cnt[m] - fe_ref[m], fe);
            checkOutput($sformatf("%s_ur_d%0d", tag, m), ur_cnt[m] - ur_ref[m],
                        (m % 2 == 0) ? ur_cpha0 : ur_cpha1);
            checkOutput($sformatf("%s_rxleft_d%0d", tag, m), exp_rx[m].size(), 0);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int m = 0; m < 5; m++) begin
            fs_cnt[m] = 0;
            fe_cnt[m] = 0;
            ur_cnt[m] = 0;
        end
        reset      = 1'b1;
        sck_base   = 1'b0;
        ss_a       = 1'b1;
        ss_b       = 1'b1;
        mosi       = 1'b0;
        tx_data8   = '0;
        tx_valid8  = 1'b0;
        tx_data16  = '0;
        tx_valid16 = 1'b0;
        repeat (4) @(negedge clk);

        for (int m = 0; m < 5; m++) begin
            checkOutput($sformatf("rst_miso_d%0d", m), miso_all[m], 0);
            checkOutput($sformatf("rst_oe_d%0d", m), miso_oe_all[m], 0);
            checkOutput($sformatf("rst_ready_d%0d", m), tx_ready_all[m], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 5; m++) begin
            checkOutput($sformatf("post_rst_ready_d%0d", m), tx_ready_all[m], 1);
        end
        repeat (6) @(negedge clk);

        // Single word in all four modes: hold 0x3C, master sends 0xA5
        writeHold(1'b0, 16'h003C);
        pushModes(8'h3C, 1'b1, 8'hA5);
        snapCounts();
        applyStimulus(1'b0, 8, 48'h0000_0000_00A5, 1'b0);
        repeat (4) @(negedge clk);
        checkDeltas("single", 1, 1, 1, 0);
        checkOutput("single_rx_hold", rx_data8[1], 8'hA5);
        checkOutput("single_ready", tx_ready_all[1], 1);

        // Three words, only the first supplied
        writeHold(1'b0, 16'h0011);
        for (int m = 0; m < 4; m++) begin
            exp_miso[m].push_back(16'h0011);
            exp_miso[m].push_back(16'h0000);
            exp_miso[m].push_back(16'h0000);
            exp_rx[m].push_back({1'b1, 16'h0001});
            exp_rx[m].push_back({1'b0, 16'h0002});
            exp_rx[m].push_back({1'b0, 16'h0003});
        end
        snapCounts();
        applyStimulus(1'b0, 24, 48'h0000_0003_0201, 1'b0);
        repeat (4) @(negedge clk);
        checkDeltas("multi", 1, 1, 3, 2);

        // SS raised after 5 bits: partial word dropped, loaded word consumed
        writeHold(1'b0, 16'h005A);
        snapCounts();
        applyStimulus(1'b0, 5, 48'h0000_0000_00FF, 1'b0);
        repeat (4) @(negedge clk);
        checkDeltas("abort", 1, 1, 0, 0);
        checkOutput("abort_ready", tx_ready_all[3], 1);
        pushModes(8'h00, 1'b1, 8'h81);
        snapCounts();
        applyStimulus(1'b0, 8, 48'h0000_0000_0081, 1'b0);
        repeat (4) @(negedge clk);
        checkDeltas("after_abort", 1, 1, 2, 1);

        // 16-bit LSB-first slave
        writeHold(1'b1, 16'hBEEF);
        exp_miso[4].push_back(16'hBEEF);
        exp_rx[4].push_back({1'b1, 16'h1234});
        snapCounts();
        applyStimulus(1'b1, 16, 48'h0000_0000_1234, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("w16_rx_hold", rx_data16, 16'h1234);
        checkOutput("w16_ur", ur_cnt[4] - ur_ref[4], 0);
        checkOutput("w16_fe", fe_cnt[4] - fe_ref[4], 1);
        checkOutput("w16_rxleft", exp_rx[4].size(), 0);

        // Reset in the middle of a word
        writeHold(1'b0, 16'h0077);
        applyStimulus(1'b0, 3, 48'h0000_0000_00FF, 1'b1);
        snapCounts();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("midrst_miso_d%0d", m), miso_all[m], 0);
            checkOutput($sformatf("midrst_oe_d%0d", m), miso_oe_all[m], 0);
            checkOutput($sformatf("midrst_ready_d%0d", m), tx_ready_all[m], 0);
        end
        ss_a = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midrst_fe", fe_cnt[0] - fe_ref[0], 0);
        checkOutput("midrst_ready", tx_ready_all[0], 1);
        writeHold(1'b0, 16'h0096);
        pushModes(8'h96, 1'b1, 8'hC3);
        snapCounts();
        applyStimulus(1'b0, 8, 48'h0000_0000_00C3, 1'b0);
        repeat (4) @(negedge clk);
        checkDeltas("post_rst", 1, 1, 1, 0);

        for (int m = 0; m < 5; m++) begin
            checkOutput($sformatf("final_miso_left_d%0d", m), exp_miso[m].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
